// File: rtl/block_memory_storage_pkg.sv
// Shared constants and store state encoding for the hit-list memory storage path.
package block_memory_storage_pkg;

   localparam int SSIDBITS_DEFAULT  = 10;
   localparam int NCOLS_HLM_DEFAULT = 16;

   typedef enum logic [1:0] {
      STORE_CLEAR = 2'd0,
      STORE_IDLE  = 2'd1,
      STORE_READ  = 2'd2
   } storeState_t;

   function automatic int depthOf(input int ssidBits);
      return 1 << ssidBits;
   endfunction

endpackage

// File: rtl/block_memory_storage_address_counter.sv
// Write source: walks SSID through the whole address space while rotating a one-hot hitInfo.
module address_counter
   import block_memory_storage_pkg::*;
#(
   parameter int SSIDBITS  = SSIDBITS_DEFAULT,
   parameter int NCOLS_HLM = NCOLS_HLM_DEFAULT
) (
   input  logic                 clock,
   input  logic                 resetN,
   input  logic                 ready,
   output logic                 newAddress,
   output logic [SSIDBITS-1:0]  SSID,
   output logic [NCOLS_HLM-1:0] hitInfo
);

   logic [NCOLS_HLM-1:0] hitNext;

   // Rotate left by one: bit gi takes bit gi-1, MSB wraps into bit 0.
   genvar gi;
   generate
      for (gi = 0; gi < NCOLS_HLM; gi++) begin : g_rot
         assign hitNext[gi] = hitInfo[(gi + NCOLS_HLM - 1) % NCOLS_HLM];
      end
   endgenerate

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         newAddress <= 1'b0;
         SSID       <= '0;
         hitInfo    <= NCOLS_HLM'(1);
      end else begin
         newAddress <= 1'b1;
         if (newAddress && ready) begin
            SSID    <= SSID + SSIDBITS'(1);
            hitInfo <= hitNext;
         end
      end
   end

endmodule

// File: rtl/block_memory_storage.sv
// Hit-list memory store: OR-accumulating RMW into block RAM, full clear and full sweep readout.
module block_memory_storage
   import block_memory_storage_pkg::*;
#(
   parameter int SSIDBITS  = SSIDBITS_DEFAULT,
   parameter int NCOLS_HLM = NCOLS_HLM_DEFAULT
) (
   input  logic                 clock,
   input  logic                 resetN,
   input  logic                 clearMemory,
   input  logic                 readMemory,
   output logic                 storageReady,
   output logic                 newAddress,
   output logic [SSIDBITS-1:0]  SSID,
   output logic [NCOLS_HLM-1:0] hitInfo,
   output logic                 readValid,
   output logic [SSIDBITS-1:0]  readSSID,
   output logic [NCOLS_HLM-1:0] readData,
   output logic                 readReady
);

   localparam int DEPTH = depthOf(SSIDBITS);

   logic                 wrValid;
   logic [SSIDBITS-1:0]  wrAddr;
   logic [NCOLS_HLM-1:0] wrData;
   logic                 accept;

   storeState_t          state;
   logic [SSIDBITS-1:0]  clrPtr;
   logic [SSIDBITS-1:0]  rdPtr;
   logic                 rdDone;

   logic                 s1Valid;
   logic [SSIDBITS-1:0]  s1Addr;
   logic [NCOLS_HLM-1:0] s1Data;
   logic                 fwdValid;
   logic [SSIDBITS-1:0]  fwdAddr;
   logic [NCOLS_HLM-1:0] fwdData;
   logic [NCOLS_HLM-1:0] merged;

   logic [NCOLS_HLM-1:0] mem [DEPTH];
   logic [NCOLS_HLM-1:0] ramQ;
   logic                 ramWe;
   logic [SSIDBITS-1:0]  ramWAddr;
   logic [NCOLS_HLM-1:0] ramWData;
   logic [SSIDBITS-1:0]  ramRAddr;

   address_counter #(
      .SSIDBITS  (SSIDBITS),
      .NCOLS_HLM (NCOLS_HLM)
   ) u_counter (
      .clock      (clock),
      .resetN     (resetN),
      .ready      (storageReady),
      .newAddress (newAddress),
      .SSID       (SSID),
      .hitInfo    (hitInfo)
   );

   assign wrValid      = newAddress;
   assign wrAddr       = SSID;
   assign wrData       = hitInfo;
   assign storageReady = (state == STORE_IDLE);
   assign accept       = wrValid && storageReady;
   assign readData     = readValid ? ramQ : '0;

   // The word written on the previous edge was read stale by the current stage; forward it.
   assign merged = s1Data | ((fwdValid && (fwdAddr == s1Addr)) ? fwdData : ramQ);

   always_comb begin
      ramWe    = 1'b0;
      ramWAddr = s1Addr;
      ramWData = merged;
      ramRAddr = wrAddr;
      if (state == STORE_CLEAR) begin
         ramWe    = 1'b1;
         ramWAddr = clrPtr;
         ramWData = '0;
      end else if (s1Valid && !clearMemory) begin
         ramWe = 1'b1;
      end
      if (state == STORE_READ) begin
         ramRAddr = rdPtr;
      end
   end

   always_ff @(posedge clock) begin
      if (ramWe) begin
         mem[ramWAddr] <= ramWData;
      end
      ramQ <= mem[ramRAddr];
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state     <= STORE_CLEAR;
         clrPtr    <= '0;
         rdPtr     <= '0;
         rdDone    <= 1'b0;
         s1Valid   <= 1'b0;
         s1Addr    <= '0;
         s1Data    <= '0;
         fwdValid  <= 1'b0;
         fwdAddr   <= '0;
         fwdData   <= '0;
         readValid <= 1'b0;
         readSSID  <= '0;
         readReady <= 1'b0;
      end else begin
         s1Valid   <= accept && !clearMemory;
         s1Addr    <= wrAddr;
         s1Data    <= wrData;
         fwdValid  <= s1Valid && !clearMemory;
         fwdAddr   <= s1Addr;
         fwdData   <= merged;
         readValid <= 1'b0;
         readReady <= 1'b0;
         if (clearMemory) begin
            state  <= STORE_CLEAR;
            clrPtr <= '0;
         end else begin
            case (state)
               STORE_CLEAR: begin
                  clrPtr <= clrPtr + SSIDBITS'(1);
                  if (clrPtr == '1) begin
                     state <= STORE_IDLE;
                  end
               end
               STORE_IDLE: begin
                  if (readMemory) begin
                     state  <= STORE_READ;
                     rdPtr  <= '0;
                     rdDone <= 1'b0;
                  end
               end
               STORE_READ: begin
                  // Hold the sweep until the last accepted write has landed in RAM.
                  if (!s1Valid) begin
                     if (!rdDone) begin
                        readValid <= 1'b1;
                        readSSID  <= rdPtr;
                        rdPtr     <= rdPtr + SSIDBITS'(1);
                        if (rdPtr == '1) begin
                           rdDone <= 1'b1;
                        end
                     end else begin
                        readReady <= 1'b1;
                        state     <= STORE_IDLE;
                     end
                  end
               end
               default: state <= STORE_CLEAR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_block_memory_storage.sv
// Scoreboard bench for block_memory_storage with SSIDBITS=4, NCOLS_HLM=5.
module tb_block_memory_storage;

   localparam int SB    = 4;
   localparam int NC    = 5;
   localparam int DEPTH = 16;
   localparam int M_CLEAR = 0;
   localparam int M_IDLE  = 1;
   localparam int M_READ  = 2;

   typedef struct packed {
      logic [SB-1:0] ssid;
      logic [NC-1:0] data;
   } beat_t;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          clearMemory = 1'b0;
   logic          readMemory = 1'b0;
   logic          storageReady;
   logic          newAddress;
   logic [SB-1:0] SSID;
   logic [NC-1:0] hitInfo;
   logic          readValid;
   logic [SB-1:0] readSSID;
   logic [NC-1:0] readData;
   logic          readReady;

   block_memory_storage #(
      .SSIDBITS  (SB),
      .NCOLS_HLM (NC)
   ) dut (
      .clock        (clock),
      .resetN       (resetN),
      .clearMemory  (clearMemory),
      .readMemory   (readMemory),
      .storageReady (storageReady),
      .newAddress   (newAddress),
      .SSID         (SSID),
      .hitInfo      (hitInfo),
      .readValid    (readValid),
      .readSSID     (readSSID),
      .readData     (readData),
      .readReady    (readReady)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model of the store and counter
   int            mState;
   int            mClrCnt;
   logic [SB-1:0] mSsid;
   logic [NC-1:0] mHit;
   logic          mNewAddr;
   logic          expRdy;
   logic          mReadyDue;
   logic          mStarted;
   int            mWait;
   logic [NC-1:0] mMem [DEPTH];
   logic          fOn = 1'b0;
   logic [SB-1:0] fAddr = '0;
   logic [NC-1:0] fData = '0;
   beat_t         sb [$];

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mState    = M_CLEAR;
      mClrCnt   = 0;
      mSsid     = '0;
      mHit      = NC'(1);
      mNewAddr  = 1'b0;
      expRdy    = 1'b0;
      mReadyDue = 1'b0;
      mStarted  = 1'b0;
      mWait     = 0;
      sb.delete();
      for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
   endtask

   // Advance the model across the coming rising edge using the inputs just driven.
   task automatic predict(input logic clr, input logic rd);
      logic          acc;
      logic [SB-1:0] wa;
      logic [NC-1:0] wd;
      beat_t         b;
      acc = mNewAddr && (mState == M_IDLE);
      wa  = fOn ? fAddr : mSsid;
      wd  = fOn ? fData : mHit;
      mNewAddr = 1'b1;
      expRdy   = 1'b0;
      if (acc) begin
         mSsid = mSsid + SB'(1);
         mHit  = {mHit[NC-2:0], mHit[NC-1]};
      end
      if (clr) begin
         mState    = M_CLEAR;
         mClrCnt   = 0;
         mReadyDue = 1'b0;
         mStarted  = 1'b0;
         sb.delete();
         for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
      end else if (mState == M_CLEAR) begin
         if (mClrCnt == DEPTH - 1) mState = M_IDLE;
         mClrCnt++;
      end else if (mState == M_IDLE) begin
         if (acc) mMem[wa] = mMem[wa] | wd;
         if (rd) begin
            mState   = M_READ;
            mWait    = 0;
            mStarted = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
               b.ssid = SB'(k);
               b.data = mMem[k];
               sb.push_back(b);
            end
         end
      end else if (mReadyDue) begin
         mState    = M_IDLE;
         expRdy    = 1'b1;
         mReadyDue = 1'b0;
         mStarted  = 1'b0;
      end
   endtask

   task automatic compare();
      beat_t b;
      checkValue("newAddress", 32'(newAddress), 32'(mNewAddr));
      checkValue("SSID", 32'(SSID), 32'(mSsid));
      checkValue("hitInfo", 32'(hitInfo), 32'(mHit));
      checkValue("storageReady", 32'(storageReady), 32'(mState == M_IDLE));
      checkValue("readReady", 32'(readReady), 32'(expRdy));
      if (readValid) begin
         if (sb.size() == 0) begin
            checkValue("unexpectedBeat", 32'(readValid), 32'(0));
         end else begin
            b = sb.pop_front();
            $display("beat ssid=%0d data=%02h (model %02h)", readSSID, readData, b.data);
            checkValue("readSSID", 32'(readSSID), 32'(b.ssid));
            checkValue("readData", 32'(readData), 32'(b.data));
            mStarted = 1'b1;
            if (sb.size() == 0) mReadyDue = 1'b1;
         end
      end else if (mState == M_READ && sb.size() > 0) begin
         if (mStarted) begin
            checkValue("beatGap", 32'(readValid), 32'(1));
         end else begin
            mWait++;
            if (mWait == 6) checkValue("firstBeatDelay", 32'(readValid), 32'(1));
         end
      end
   endtask

   task automatic tick(input logic clr, input logic rd);
      clearMemory = clr;
      readMemory  = rd;
      predict(clr, rd);
      @(negedge clock);
      compare();
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (mState != M_IDLE && n < 80) begin
         tick(1'b0, 1'b0);
         n++;
      end
      checkValue(tag, 32'(storageReady), 32'(1));
   endtask

   task automatic checkResetOutputs(input string tag);
      $display("reset check %s", tag);
      checkValue("rstStorageReady", 32'(storageReady), 32'(0));
      checkValue("rstReadValid", 32'(readValid), 32'(0));
      checkValue("rstReadReady", 32'(readReady), 32'(0));
      checkValue("rstNewAddress", 32'(newAddress), 32'(0));
      checkValue("rstReadSSID", 32'(readSSID), 32'(0));
      checkValue("rstReadData", 32'(readData), 32'(0));
      checkValue("rstSSID", 32'(SSID), 32'(0));
      checkValue("rstHitInfo", 32'(hitInfo), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low;
      int n;
      modelReset();
      repeat (3) @(negedge clock);
      checkResetOutputs("powerOn");
      resetN = 1'b1;
      compare();

      // storageReady must stay low for exactly DEPTH cycles of clearing
      low = 0;
      n   = 0;
      while (!storageReady && n < 40) begin
         low++;
         tick(1'b0, 1'b0);
         n++;
      end
      checkValue("clearCycles", 32'(low), 32'(DEPTH));

      // Fill once and sweep: addr k = 1<<(k%5)
      repeat (DEPTH - 1) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      waitIdle("fillReadDone");

      // Second pass wraps addresses and accumulates a second bit
      repeat (DEPTH - 1) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      waitIdle("accumulateReadDone");

      // Clear mid-stream, then read back
      repeat (10) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      waitIdle("midClearDone");
      tick(1'b0, 1'b1);
      waitIdle("postClearReadDone");

      // readMemory during CLEAR is ignored
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      repeat (4) tick(1'b0, 1'b0);
      waitIdle("ignoredReadDone");

      // clearMemory aborts a sweep without readReady
      tick(1'b0, 1'b1);
      repeat (6) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      checkValue("abortReadValid", 32'(readValid), 32'(0));
      waitIdle("abortClearDone");

      // Asynchronous reset in the middle of a sweep
      tick(1'b0, 1'b1);
      repeat (6) tick(1'b0, 1'b0);
      resetN = 1'b0;
      #1;
      checkResetOutputs("midRead");
      modelReset();
      @(negedge clock);
      compare();
      resetN = 1'b1;
      waitIdle("afterResetClear");

      // Back-to-back writes to one address exercise the forwarding path
      tick(1'b1, 1'b0);
      waitIdle("bypassClearDone");
      fOn   = 1'b1;
      fAddr = SB'(3);
      fData = NC'(1);
      force dut.wrAddr = 4'd3;
      force dut.wrData = 5'h01;
      tick(1'b0, 1'b0);
      fData = NC'(2);
      force dut.wrData = 5'h02;
      tick(1'b0, 1'b0);
      fData = NC'(4);
      force dut.wrData = 5'h04;
      tick(1'b0, 1'b1);
      release dut.wrAddr;
      release dut.wrData;
      fOn = 1'b0;
      waitIdle("bypassReadDone");
      checkValue("pendingBeats", 32'(sb.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/block_memory_storage.md
Name: block_memory_storage

Overview:
- Hit-list memory (HLM) block: an address_counter source generates (SSID, hitInfo) writes.
- A block-RAM store OR-accumulates each hitInfo into the word at address SSID.
- On request the store sweeps all addresses out as a readout stream.
- Top level of the storage datapath; the clearMemory/readMemory controls come from the system sequencer.

Parameters:
- SSIDBITS, 10, SSID width; memory depth DEPTH = 2^SSIDBITS.
- NCOLS_HLM, 16, hit-info word width (one bit per hit column).

Ports:
- clock, input, 1, single clock, rising edge.
- resetN, input, 1, asynchronous active-low reset.
- clearMemory, input, 1, synchronous request to zero the whole memory.
- readMemory, input, 1, synchronous request to sweep memory out.
- storageReady, output, 1, store is IDLE and accepts writes.
- newAddress, output, 1, counter's write-valid.
- SSID, output, SSIDBITS, current write address from counter.
- hitInfo, output, NCOLS_HLM, current write data from counter.
- readValid, output, 1, readout beat valid.
- readSSID, output, SSIDBITS, address of the readout beat.
- readData, output, NCOLS_HLM, word of the readout beat.
- readReady, output, 1, one-cycle pulse when a readout sweep completes.

Behaviour:
- Reset (resetN low, async):
  - Store enters CLEAR with clear pointer 0.
  - storageReady, readValid, readReady, newAddress are 0; readSSID and readData are 0.
  - Counter: SSID=0, hitInfo=1 (bit 0 set).
- Counter:
  - newAddress=1 in every cycle after reset release.
  - A write transfers when newAddress && storageReady at a rising edge.
  - On transfer: SSID <= SSID+1, wrapping at DEPTH-1 -> 0; hitInfo rotates left by one, MSB wraps to bit 0.
  - No transfer means outputs are held.
- Store states are CLEAR, IDLE and READ.
- CLEAR:
  - Writes 0 to one address per cycle, pointer 0..DEPTH-1; storageReady=0.
  - Moves to IDLE the cycle after address DEPTH-1 is written, so DEPTH cycles in total.
- IDLE:
  - storageReady=1.
  - An accepted write performs mem[SSID] <= mem[SSID] | hitInfo via a 2-stage read-modify-write pipeline: sync RAM read, then OR and write.
  - Bypass: a write to the same address as the in-flight stage uses forwarded data. The result must equal sequential OR for any address sequence, including back-to-back identical SSIDs.
- readMemory sampled high in IDLE:
  - Drain the write pipeline, then go to READ.
  - storageReady drops in the same edge's next cycle.
- READ:
  - Addresses 0..DEPTH-1 are read one per cycle; RAM latency is 1.
  - readValid=1 with readSSID=k and readData=mem[k] for DEPTH consecutive cycles.
  - readReady=1 for exactly one cycle, the cycle after the last beat; then return to IDLE.
  - Memory contents are unchanged by a read.
- clearMemory sampled high (sync):
  - Highest priority, from any state. Aborts READ without a readReady pulse, discards the in-flight write, restarts CLEAR at pointer 0.
  - Held high: pointer stays at 0.
- readMemory outside IDLE is ignored (not queued).
- Both readMemory and clearMemory high: clear wins.
- resetN low mid-operation: immediate abort to reset state regardless of state.

Decomposition:
- Shared package/header: SSIDBITS, NCOLS_HLM, derived DEPTH, store state encoding (CLEAR/IDLE/READ).
- Sub-module address_counter: counter plus hitInfo rotator, valid/ready handshake.
- The top contains the store FSM, RMW pipeline and RAM, inferred as simple dual-port block RAM.

Test Plan:
- All tests use SSIDBITS=4 and NCOLS_HLM=5.
- Reset/clear: pulse resetN low, release -> storageReady=0 for exactly 16 cycles, then 1; SSID=0, hitInfo=5'h01, newAddress=1.
- Fill and read:
  - Let 16 writes transfer, then pulse readMemory -> 16 beats readSSID 0..15.
  - readData = 1<<(k%5), e.g. addr 7 = 5'h04, addr 15 = 5'h01.
  - readReady pulses once, the cycle after beat 15.
- Accumulate/wrap: 32 transfers then read -> addr k = (1<<(k%5)) | (1<<((k+1)%5)); addr 0 = 5'h03, addr 4 = 5'h11.
- clearMemory mid-stream: assert after 10 writes -> storageReady low next cycle, 16 clear cycles; a subsequent read returns all 16 words = 0.
- Ignored/aborted read:
  - readMemory during CLEAR -> no readValid.
  - clearMemory during READ -> readValid drops, no readReady, CLEAR restarts.
  - resetN low during READ -> all outputs zero immediately.
- Same-address bypass: drive the store with a forced newAddress sequence SSID 3,3,3 with hitInfo 01,02,04 -> addr 3 reads 5'h07.
